// File: rtl/pc_src_pkg.sv
// Shared encodings for the PC-source sequencer: request kinds, PC mux selects,
// FSM states and default exception vector addresses.
package pc_src_pkg;

    // Request kinds from main control; codes 6 and 7 are illegal and handled as EXC.
    typedef enum logic [2:0] {
        K_NEXT   = 3'd0,
        K_BRANCH = 3'd1,
        K_JUMP   = 3'd2,
        K_JREG   = 3'd3,
        K_RTE    = 3'd4,
        K_EXC    = 3'd5
    } req_kind_t;

    // PC mux select codes; the PC mux decodes exactly these values.
    typedef enum logic [2:0] {
        SEL_ALU_DIRECT = 3'b000,
        SEL_ALU_OUT    = 3'b001,
        SEL_JUMP_SHL2  = 3'b010,
        SEL_MEM_SEXT   = 3'b011,
        SEL_EPC        = 3'b100
    } pc_sel_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PC_WR    = 3'd1,
        ST_EXC_EPC  = 3'd2,
        ST_EXC_WAIT = 3'd3,
        ST_EXC_LD   = 3'd4
    } state_t;

    // Default vector byte addresses per exception cause.
    localparam logic [31:0] DEF_VEC_OPC = 32'd253;
    localparam logic [31:0] DEF_VEC_OVF = 32'd254;
    localparam logic [31:0] DEF_VEC_DIV = 32'd255;

    // Anything that is not a plain PC update enters the exception sequence.
    function automatic logic is_exc_kind(input logic [2:0] kind);
        return (kind == K_EXC) || (kind[2:1] == 2'b11);
    endfunction

endpackage

// File: rtl/pc_wait_cnt.sv
// Loadable 4-bit down-counter with a zero flag; times the memory wait window.
module pc_wait_cnt (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load,
    input  logic       dec,
    input  logic [3:0] load_val,
    output logic       zero
);

    logic [3:0] cnt;

    // Load takes priority; decrement saturates at zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt <= 4'd0;
        else if (load)
            cnt <= load_val;
        else if (dec && (cnt != 4'd0))
            cnt <= cnt - 4'd1;
    end

    assign zero = (cnt == 4'd0);

endmodule

// File: rtl/pc_src_ctrl.sv
// PC-source sequencer: turns one PC-update request into a mux select plus a
// one-cycle PC load, and runs the multi-cycle exception entry (EPC save,
// vector byte read, PC load from memory). All outputs come from flops.
module pc_src_ctrl
    import pc_src_pkg::*;
#(
    parameter int          MEM_LAT = 1,
    parameter logic [31:0] VEC_OPC = DEF_VEC_OPC,
    parameter logic [31:0] VEC_OVF = DEF_VEC_OVF,
    parameter logic [31:0] VEC_DIV = DEF_VEC_DIV
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_kind,
    input  logic        br_cond,
    input  logic [1:0]  exc_cause,
    output logic [2:0]  pc_src_sel,
    output logic        pc_write,
    output logic        epc_write,
    output logic        vec_rd,
    output logic [31:0] vec_addr,
    output logic        done
);

    if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_mem_lat
        $error("pc_src_ctrl: MEM_LAT=%0d outside legal range 1..15", MEM_LAT);
    end

    // The counter is loaded on the way into EXC_WAIT, so it must expire after MEM_LAT cycles.
    localparam logic [3:0] WAIT_LOAD = 4'(MEM_LAT - 1);

    state_t      state, state_nx;
    logic        ready_nx, pcw_nx, epcw_nx, vrd_nx, done_nx;
    logic [2:0]  sel_nx;
    logic [31:0] vaddr_nx, exc_vec;
    logic        cnt_load, cnt_dec, cnt_zero;

    // Illegal kinds behave as a nonexistent-opcode exception.
    always_comb begin
        exc_vec = VEC_OPC;
        if (req_kind == K_EXC) begin
            case (exc_cause)
                2'd0:    exc_vec = VEC_OPC;
                2'd1:    exc_vec = VEC_OVF;
                default: exc_vec = VEC_DIV;
            endcase
        end
    end

    // Next state and next value of every registered output.
    always_comb begin
        state_nx = state;
        ready_nx = 1'b0;
        sel_nx   = SEL_ALU_DIRECT;
        pcw_nx   = 1'b0;
        epcw_nx  = 1'b0;
        vrd_nx   = 1'b0;
        done_nx  = 1'b0;
        vaddr_nx = vec_addr;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        case (state)
            ST_IDLE: begin
                ready_nx = 1'b1;
                if (req_valid && req_ready) begin
                    ready_nx = 1'b0;
                    if (is_exc_kind(req_kind)) begin
                        state_nx = ST_EXC_EPC;
                        epcw_nx  = 1'b1;
                        vaddr_nx = exc_vec;
                    end else begin
                        state_nx = ST_PC_WR;
                        done_nx  = 1'b1;
                        pcw_nx   = 1'b1;
                        case (req_kind)
                            K_BRANCH: begin
                                sel_nx = SEL_ALU_OUT;
                                pcw_nx = br_cond;
                            end
                            K_JUMP:  sel_nx = SEL_JUMP_SHL2;
                            K_RTE:   sel_nx = SEL_EPC;
                            default: sel_nx = SEL_ALU_DIRECT;
                        endcase
                    end
                end
            end
            ST_PC_WR: begin
                state_nx = ST_IDLE;
                ready_nx = 1'b1;
            end
            ST_EXC_EPC: begin
                state_nx = ST_EXC_WAIT;
                vrd_nx   = 1'b1;
                cnt_load = 1'b1;
            end
            ST_EXC_WAIT: begin
                if (cnt_zero) begin
                    state_nx = ST_EXC_LD;
                    sel_nx   = SEL_MEM_SEXT;
                    pcw_nx   = 1'b1;
                    done_nx  = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_EXC_LD: begin
                state_nx = ST_IDLE;
                ready_nx = 1'b1;
            end
            default: begin
                state_nx = ST_IDLE;
                ready_nx = 1'b1;
            end
        endcase
    end

    // State and output registers; req_ready comes up as soon as reset is released.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            req_ready  <= 1'b1;
            pc_src_sel <= SEL_ALU_DIRECT;
            pc_write   <= 1'b0;
            epc_write  <= 1'b0;
            vec_rd     <= 1'b0;
            vec_addr   <= 32'd0;
            done       <= 1'b0;
        end else begin
            state      <= state_nx;
            req_ready  <= ready_nx;
            pc_src_sel <= sel_nx;
            pc_write   <= pcw_nx;
            epc_write  <= epcw_nx;
            vec_rd     <= vrd_nx;
            vec_addr   <= vaddr_nx;
            done       <= done_nx;
        end
    end

    pc_wait_cnt u_wait_cnt (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (WAIT_LOAD),
        .zero     (cnt_zero)
    );

endmodule

// File: tb/tb_pc_src_ctrl.sv
// Scoreboard bench for pc_src_ctrl: stimulus pushes hand-computed expected
// events (done/select/pc_write, epc_write, vec_rd with cycle and vector);
// a negedge monitor pops and compares whenever the DUT raises one.
module tb_pc_src_ctrl;

    localparam int ML = 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_kind = 3'd0;
    logic        br_cond = 1'b0;
    logic [1:0]  exc_cause = 2'd0;
    logic [2:0]  pc_src_sel;
    logic        pc_write, epc_write, vec_rd, done;
    logic [31:0] vec_addr;

    pc_src_ctrl #(.MEM_LAT(ML)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_kind   (req_kind),
        .br_cond    (br_cond),
        .exc_cause  (exc_cause),
        .pc_src_sel (pc_src_sel),
        .pc_write   (pc_write),
        .epc_write  (epc_write),
        .vec_rd     (vec_rd),
        .vec_addr   (vec_addr),
        .done       (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errs = 0;
    int checks = 0;

    typedef struct {
        int          cyc;
        logic [2:0]  sel;
        logic        pcw;
        logic [31:0] vaddr;
        logic        chk_va;
    } done_exp_t;

    typedef struct {
        int          cyc;
        logic [31:0] vaddr;
    } ev_exp_t;

    done_exp_t dq[$];
    ev_exp_t   eq[$];
    ev_exp_t   rq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops an expectation for every done/epc_write/vec_rd the DUT raises.
    always @(negedge clk) begin
        done_exp_t d;
        ev_exp_t   e;
        if (reset_n) begin
            chk("pcw_epcw_exclusive", {31'd0, pc_write & epc_write}, 32'd0);
            chk("pcw_without_done", {31'd0, pc_write & ~done}, 32'd0);
            if (done) begin
                if (dq.size() == 0) chk("unexpected_done", {31'd0, done}, 32'd0);
                else begin
                    d = dq.pop_front();
                    chk("done_cycle", cyc, d.cyc);
                    chk("pc_src_sel", {29'd0, pc_src_sel}, {29'd0, d.sel});
                    chk("pc_write", {31'd0, pc_write}, {31'd0, d.pcw});
                    if (d.chk_va) chk("vec_addr_at_ld", vec_addr, d.vaddr);
                end
            end
            if (epc_write) begin
                if (eq.size() == 0) chk("unexpected_epc_write", {31'd0, epc_write}, 32'd0);
                else begin
                    e = eq.pop_front();
                    chk("epc_cycle", cyc, e.cyc);
                    chk("vec_addr_at_epc", vec_addr, e.vaddr);
                end
            end
            if (vec_rd) begin
                if (rq.size() == 0) chk("unexpected_vec_rd", {31'd0, vec_rd}, 32'd0);
                else begin
                    e = rq.pop_front();
                    chk("vec_rd_cycle", cyc, e.cyc);
                    chk("vec_addr_at_rd", vec_addr, e.vaddr);
                end
            end
        end
    end

    // Issue one request from a negedge; pushes expectations at accept. Returns at
    // the negedge after accept. hold keeps req_valid asserted afterwards.
    task automatic issue(input logic [2:0] kind, input logic br, input logic [1:0] cause,
                         input logic exc, input logic [2:0] esel, input logic epcw,
                         input logic [31:0] eva, input logic hold, output int t);
        int n = 0;
        req_kind  = kind;
        br_cond   = br;
        exc_cause = cause;
        req_valid = 1'b1;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("ready_timeout", {31'd0, req_ready}, 32'd1);
            req_valid = 1'b0;
            t = -1;
            return;
        end
        t = cyc;
        if (exc) begin
            eq.push_back('{t + 1, eva});
            rq.push_back('{t + 2, eva});
            dq.push_back('{t + 2 + ML, 3'b011, 1'b1, eva, 1'b1});
        end else begin
            dq.push_back('{t + 1, esel, epcw, 32'd0, 1'b0});
        end
        @(negedge clk);
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        int t1, t2;
        #1;
        chk("rst_sel", {29'd0, pc_src_sel}, 32'd0);
        chk("rst_strobes", {28'd0, pc_write, epc_write, vec_rd, done}, 32'd0);
        chk("rst_vec_addr", vec_addr, 32'd0);
        idle(2);
        reset_n = 1'b1;
        idle(1);
        chk("ready_after_rst", {31'd0, req_ready}, 32'd1);

        // NEXT, then ready again two cycles after accept
        issue(3'd0, 1'b0, 2'd0, 1'b0, 3'b000, 1'b1, 32'd0, 1'b0, t1);
        chk("busy_in_pc_wr", {31'd0, req_ready}, 32'd0);
        idle(1);
        chk("ready_at_T2", {31'd0, req_ready}, 32'd1);

        // BRANCH not taken / taken
        issue(3'd1, 1'b0, 2'd0, 1'b0, 3'b001, 1'b0, 32'd0, 1'b0, t1);
        issue(3'd1, 1'b1, 2'd0, 1'b0, 3'b001, 1'b1, 32'd0, 1'b0, t1);

        // EXC overflow -> vector 254
        issue(3'd5, 1'b0, 2'd1, 1'b1, 3'b011, 1'b1, 32'd254, 1'b0, t1);
        idle(ML + 3);

        // Illegal kind 7 with req_valid held through the whole sequence
        issue(3'd7, 1'b0, 2'd2, 1'b1, 3'b011, 1'b1, 32'd253, 1'b1, t1);
        for (int i = 0; i < ML + 2; i++) begin
            chk("held_busy_ready", {31'd0, req_ready}, 32'd0);
            @(negedge clk);
        end
        chk("held_ready_back", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b0;
        idle(2);

        // RTE
        issue(3'd4, 1'b0, 2'd0, 1'b0, 3'b100, 1'b1, 32'd0, 1'b0, t1);

        // Back-to-back JUMP, JREG
        issue(3'd2, 1'b0, 2'd0, 1'b0, 3'b010, 1'b1, 32'd0, 1'b0, t1);
        issue(3'd3, 1'b0, 2'd0, 1'b0, 3'b000, 1'b1, 32'd0, 1'b0, t2);
        chk("b2b_spacing", t2 - t1, 32'd2);

        // Remaining cause mappings and illegal kind 6
        issue(3'd5, 1'b0, 2'd3, 1'b1, 3'b011, 1'b1, 32'd255, 1'b0, t1);
        issue(3'd5, 1'b0, 2'd0, 1'b1, 3'b011, 1'b1, 32'd253, 1'b0, t1);
        issue(3'd6, 1'b0, 2'd1, 1'b1, 3'b011, 1'b1, 32'd253, 1'b0, t1);
        issue(3'd5, 1'b0, 2'd2, 1'b1, 3'b011, 1'b1, 32'd255, 1'b0, t1);
        idle(ML + 3);

        // Async reset in the middle of EXC_WAIT
        issue(3'd5, 1'b0, 2'd2, 1'b1, 3'b011, 1'b1, 32'd255, 1'b0, t1);
        idle(1);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_sel", {29'd0, pc_src_sel}, 32'd0);
        chk("async_rst_strobes", {28'd0, pc_write, epc_write, vec_rd, done}, 32'd0);
        chk("async_rst_vec_addr", vec_addr, 32'd0);
        dq.delete();
        eq.delete();
        rq.delete();
        idle(2);
        reset_n = 1'b1;
        idle(ML + 4);
        issue(3'd0, 1'b0, 2'd0, 1'b0, 3'b000, 1'b1, 32'd0, 1'b0, t1);

        // Drain with a bound
        for (int i = 0; i < 30 && (dq.size() + eq.size() + rq.size()) != 0; i++) @(negedge clk);
        chk("drain_outstanding", dq.size() + eq.size() + rq.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
